uart_rx_framer: RTL and testbench

//  Next-generation UART receive bridge. Sits between the FTDI byte link layer (ll_*) and the controller (ctrl_*).

---
 rtl/uart_bridge_pkg.sv | 28 ++
 rtl/uart_frame_slots.sv | 121 ++++++++++++
 rtl/uart_rx_framer.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uart_bridge_pkg
// Shared types and helpers for the UART receive bridge.
//   rx_state_t : framer FSM states (S_CHK is only entered when the build
//                defines RX_CHECKSUM_EN)
//   LEN_W      : width of the LEN field in the low bits of the header
//   msg_bytes  : payload capacity in bytes for a given MESSAGE_SIZE
//   hdr_bytes  : header length in bytes for a given HEADER_SIZE
// ---------------------------------------------------------------------------
package uart_bridge_pkg;

   localparam int LEN_W = 16;

   typedef enum logic [1:0] {
      S_HDR = 2'd0,
      S_PAY = 2'd1,
      S_CHK = 2'd2
   } rx_state_t;

   function automatic int msg_bytes(input int message_size);
      return message_size / 8;
   endfunction

   function automatic int hdr_bytes(input int header_size);
      return header_size / 8;
   endfunction

endpackage

// File: rtl/uart_frame_slots.sv
// ---------------------------------------------------------------------------
// uart_frame_slots
// NUM_SLOTS-deep frame buffer holding header, message and error flag per slot.
// The writer builds a frame in place in slot[wr_ptr]; a commit publishes it.
// The reader sees slot[rd_ptr] directly; a pop releases it.
// Ports:
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   i_clr              clear message/err of the write slot (first header byte)
//   i_hdr_we, i_byte   shift i_byte into the write slot header (first byte ends at MSB)
//   i_msg_we, i_msg_idx write i_byte into message byte lane i_msg_idx (lane 0 = MSBs)
//   i_err_set          set the write slot error flag
//   i_commit, i_pop    publish write slot / release read slot
//   o_header, o_message, o_err  contents of the read slot
//   o_full, o_empty    occupancy flags
// ---------------------------------------------------------------------------
module uart_frame_slots
   import uart_bridge_pkg::*;
#(
   parameter int MESSAGE_SIZE = 512,
   parameter int HEADER_SIZE  = 32,
   parameter int NUM_SLOTS    = 2,
   parameter int MSG_BYTES    = MESSAGE_SIZE / 8,
   parameter int IDX_W        = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    i_clr,
   input  logic                    i_hdr_we,
   input  logic [7:0]              i_byte,
   input  logic                    i_msg_we,
   input  logic [IDX_W-1:0]        i_msg_idx,
   input  logic                    i_err_set,
   input  logic                    i_commit,
   input  logic                    i_pop,
   output logic [HEADER_SIZE-1:0]  o_header,
   output logic [MESSAGE_SIZE-1:0] o_message,
   output logic                    o_err,
   output logic                    o_full,
   output logic                    o_empty
);

   localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CNT_W = $clog2(NUM_SLOTS + 1);

   logic [HEADER_SIZE-1:0]  r_hdr [NUM_SLOTS];
   logic [MESSAGE_SIZE-1:0] r_msg [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]    r_err;
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic [MSG_BYTES-1:0]    w_lane_we;
   logic                    w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Byte-lane decode of the payload write index
   for (genvar gi = 0; gi < MSG_BYTES; gi++) begin : g_lane
      assign w_lane_we[gi] = i_msg_we && (i_msg_idx == IDX_W'(gi));
   end

   assign w_pop   = i_pop && (r_count != '0);
   assign o_full  = (r_count == CNT_W'(NUM_SLOTS));
   assign o_empty = (r_count == '0);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            r_hdr[s] <= '0;
            r_msg[s] <= '0;
         end
         r_err <= '0;
      end else begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (r_wr_ptr == PTR_W'(s)) begin
               if (i_hdr_we)
                  r_hdr[s] <= {r_hdr[s][HEADER_SIZE-9:0], i_byte};
               if (i_clr) begin
                  r_msg[s] <= '0;
                  r_err[s] <= 1'b0;
               end else begin
                  for (int b = 0; b < MSG_BYTES; b++)
                     if (w_lane_we[b])
                        r_msg[s][MESSAGE_SIZE-1-8*b -: 8] <= i_byte;
                  if (i_err_set)
                     r_err[s] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_commit) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
         // Commit and pop together leave the occupancy unchanged
         if (i_commit && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!i_commit && w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   always_comb begin
      o_header  = '0;
      o_message = '0;
      o_err     = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (r_rd_ptr == PTR_W'(s)) begin
            o_header  = r_hdr[s];
            o_message = r_msg[s];
            o_err     = r_err[s];
         end
      end
   end

endmodule

// File: rtl/uart_rx_framer.sv
// ---------------------------------------------------------------------------
// uart_rx_framer
// Receive bridge between the byte link layer (ll_*) and the controller.
// Parses [header | LEN payload bytes] frames, buffers complete frames in
// uart_frame_slots and aborts partial frames after an inter-byte timeout.
// Build option: define RX_CHECKSUM_EN to expect one trailing checksum byte
// per frame with a non-zero LEN (state S_CHK); a bad sum flags the frame.
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   ll_valid_in, ll_byte_in   incoming byte; ll_ready_out = buffer not full
//   message_out, header_out, frame_err_out  head frame contents
//   bdge_valid_out, ctrl_ready_in           head frame handshake
//   timeout_out               one-cycle pulse when a partial frame is dropped
// ---------------------------------------------------------------------------
module uart_rx_framer
   import uart_bridge_pkg::*;
#(
   parameter int MESSAGE_SIZE   = 512,
   parameter int HEADER_SIZE    = 32,
   parameter int LEN_WIDTH      = LEN_W,
   parameter int NUM_SLOTS      = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   output logic [MESSAGE_SIZE-1:0] message_out,
   output logic [HEADER_SIZE-1:0]  header_out,
   output logic                    frame_err_out,
   input  logic                    ctrl_ready_in,
   output logic                    bdge_valid_out,
   input  logic                    ll_valid_in,
   input  logic [7:0]              ll_byte_in,
   output logic                    ll_ready_out,
   output logic                    timeout_out
);

   localparam int MSG_BYTES = msg_bytes(MESSAGE_SIZE);
   localparam int HDR_BYTES = hdr_bytes(HEADER_SIZE);
   localparam int IDX_W     = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
   localparam int TMO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   rx_state_t            r_state;
   logic [LEN_WIDTH-1:0] r_bcnt;
   logic [LEN_WIDTH-1:0] r_len;
   logic [TMO_W-1:0]     r_idle;
   logic                 r_timeout;
`ifdef RX_CHECKSUM_EN
   logic [7:0]           r_sum;
   logic [7:0]           w_sum_next;
`endif

   logic                 w_full, w_empty, w_acc;
   logic                 w_clr, w_hdr_we, w_msg_we, w_err_set, w_commit;
   logic [LEN_WIDTH-1:0] w_len_now;
   logic                 w_hdr_last, w_pay_last, w_in_msg;
   logic                 w_active, w_tmo_hit;

   assign w_acc          = ll_valid_in && !w_full;
   assign ll_ready_out   = !w_full;
   assign bdge_valid_out = !w_empty;
   assign timeout_out    = r_timeout;

   // LEN is the last LEN_WIDTH/8 header bytes, so a running shift holds it
   assign w_len_now  = {r_len[LEN_WIDTH-9:0], ll_byte_in};
   assign w_hdr_last = (r_bcnt == LEN_WIDTH'(HDR_BYTES - 1));
   assign w_pay_last = (r_bcnt == r_len - LEN_WIDTH'(1));
   assign w_in_msg   = (r_bcnt < LEN_WIDTH'(MSG_BYTES));
`ifdef RX_CHECKSUM_EN
   assign w_sum_next = r_sum + ll_byte_in;
`endif

   // Idle time only matters once a frame has started; a full buffer is
   // back-pressure, not a stalled sender, so it freezes the counter.
   assign w_active  = (r_state != S_HDR) || (r_bcnt != '0);
   assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && !w_acc && w_active && !w_full &&
                      (r_idle == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_clr     = 1'b0;
      w_hdr_we  = 1'b0;
      w_msg_we  = 1'b0;
      w_err_set = 1'b0;
      w_commit  = 1'b0;
      if (w_acc) begin
         case (r_state)
            S_HDR: begin
               w_hdr_we = 1'b1;
               w_clr    = (r_bcnt == '0);
               w_commit = w_hdr_last && (w_len_now == '0);
            end
            S_PAY: begin
               w_msg_we  = w_in_msg;
               w_err_set = !w_in_msg;   // only reachable when LEN > MSG_BYTES
`ifndef RX_CHECKSUM_EN
               w_commit  = w_pay_last;
`endif
            end
`ifdef RX_CHECKSUM_EN
            S_CHK: begin
               w_err_set = (w_sum_next != 8'd0);
               w_commit  = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state   <= S_HDR;
         r_bcnt    <= '0;
         r_len     <= '0;
         r_idle    <= '0;
         r_timeout <= 1'b0;
`ifdef RX_CHECKSUM_EN
         r_sum     <= '0;
`endif
      end else begin
         r_timeout <= 1'b0;
         if (w_acc) begin
            r_idle <= '0;
            case (r_state)
               S_HDR: begin
                  r_len <= w_len_now;
`ifdef RX_CHECKSUM_EN
                  r_sum <= (r_bcnt == '0) ? ll_byte_in : w_sum_next;
`endif
                  if (w_hdr_last) begin
                     r_bcnt <= '0;
                     // A zero-length frame commits on its last header byte
                     if (w_len_now != '0) r_state <= S_PAY;
                  end else begin
                     r_bcnt <= r_bcnt + LEN_WIDTH'(1);
                  end
               end
               S_PAY: begin
`ifdef RX_CHECKSUM_EN
                  r_sum <= w_sum_next;
`endif
                  if (w_pay_last) begin
                     r_bcnt <= '0;
`ifdef RX_CHECKSUM_EN
                     r_state <= S_CHK;
`else
                     r_state <= S_HDR;
`endif
                  end else begin
                     r_bcnt <= r_bcnt + LEN_WIDTH'(1);
                  end
               end
               default: r_state <= S_HDR;
            endcase
         end else if (w_tmo_hit) begin
            r_state   <= S_HDR;
            r_bcnt    <= '0;
            r_idle    <= '0;
            r_timeout <= 1'b1;
         end else if (!w_active) begin
            r_idle <= '0;
         end else if (!w_full && (TIMEOUT_CYCLES != 0)) begin
            r_idle <= r_idle + TMO_W'(1);
         end
      end
   end

   uart_frame_slots #(
      .MESSAGE_SIZE (MESSAGE_SIZE),
      .HEADER_SIZE  (HEADER_SIZE),
      .NUM_SLOTS    (NUM_SLOTS),
      .MSG_BYTES    (MSG_BYTES),
      .IDX_W        (IDX_W)
   ) u_slots (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .i_clr     (w_clr),
      .i_hdr_we  (w_hdr_we),
      .i_byte    (ll_byte_in),
      .i_msg_we  (w_msg_we),
      .i_msg_idx (r_bcnt[IDX_W-1:0]),
      .i_err_set (w_err_set),
      .i_commit  (w_commit),
      .i_pop     (ctrl_ready_in),
      .o_header  (header_out),
      .o_message (message_out),
      .o_err     (frame_err_out),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

endmodule

// File: tb/tb_uart_rx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_framer
// Directed bench for uart_rx_framer (default parameters). Frames are modelled
// when driven and queued; each pop compares the DUT head frame to the queue.
// Honours RX_CHECKSUM_EN: appends checksum bytes and checks corrupted ones.
// ---------------------------------------------------------------------------
module tb_uart_rx_framer;

   typedef struct {
      logic [31:0]  hdr;
      logic [511:0] msg;
      logic         err;
   } exp_t;

`ifdef RX_CHECKSUM_EN
   localparam bit CHK_BUILD = 1'b1;
`else
   localparam bit CHK_BUILD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [511:0] message;
   logic [31:0]  header;
   logic         frame_err;
   logic         ctrl_ready;
   logic         bdge_valid;
   logic         ll_valid;
   logic [7:0]   ll_byte;
   logic         ll_ready;
   logic         timeout;

   exp_t         sb[$];
   logic [7:0]   pay [0:127];
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   uart_rx_framer dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .message_out    (message),
      .header_out     (header),
      .frame_err_out  (frame_err),
      .ctrl_ready_in  (ctrl_ready),
      .bdge_valid_out (bdge_valid),
      .ll_valid_in    (ll_valid),
      .ll_byte_in     (ll_byte),
      .ll_ready_out   (ll_ready),
      .timeout_out    (timeout)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_pay(input int seed);
      for (int k = 0; k < 128; k++) pay[k] = 8'(seed * 17 + k * 37 + 1);
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      ll_valid = 1'b1;
      ll_byte  = b;
      while (!ll_ready && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      if (!ll_ready) check("byte_accept_wait", ll_ready, 1);
      @(posedge clk);
      @(negedge clk);
      ll_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] hdr, input bit corrupt);
      exp_t       e;
      int         len;
      logic [7:0] sum;
      len   = int'(hdr[15:0]);
      sum   = 8'd0;
      e.hdr = hdr;
      e.msg = '0;
      e.err = (len > 64) || (CHK_BUILD && corrupt && len != 0);
      for (int k = 0; k < len && k < 64; k++) e.msg[511-8*k -: 8] = pay[k];
      sb.push_back(e);
      for (int i = 0; i < 4; i++) begin
         sum = sum + hdr[31-8*i -: 8];
         send_byte(hdr[31-8*i -: 8]);
      end
      for (int k = 0; k < len; k++) begin
         sum = sum + pay[k];
         send_byte(pay[k]);
      end
      if (CHK_BUILD && len != 0) send_byte((8'd0 - sum) ^ (corrupt ? 8'h01 : 8'h00));
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      int   waited = 0;
      while (!bdge_valid && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_valid"}, bdge_valid, 1);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_sb observed=no_expected_frame expected=queued_frame", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_hdr"}, header, e.hdr);
         check({tag, "_msg"}, message, e.msg);
         check({tag, "_err"}, frame_err, e.err);
      end
      ctrl_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ctrl_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n      = 1'b0;
      ll_valid   = 1'b0;
      ll_byte    = 8'd0;
      ctrl_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", bdge_valid, 0);
      check("rst_hdr", header, 0);
      check("rst_msg", message, 0);
      check("rst_err", frame_err, 0);
      check("rst_tmo", timeout, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", ll_ready, 1);

      // 1: basic frame, AA BB CC
      fill_pay(0);
      pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
      send_frame(32'h0000_0003, 1'b0);
      check("t1_latency", bdge_valid, 1);
      pop_check("t1");
      check("t1_empty", bdge_valid, 0);

      // 2: fill both slots, third frame stalls until a pop
      fill_pay(1); send_frame(32'h0001_0002, 1'b0);
      fill_pay(2); send_frame(32'h0002_0001, 1'b0);
      check("t2_full", ll_ready, 0);
      fill_pay(3);
      fork
         send_frame(32'h0003_0003, 1'b0);
         begin
            repeat (10) @(negedge clk);
            check("t2_held", ll_ready, 0);
            pop_check("t2_f1");
         end
      join
      pop_check("t2_f2");
      pop_check("t2_f3");
      check("t2_empty", bdge_valid, 0);

      // 3: LEN beyond capacity, then a clean frame
      fill_pay(4); send_frame(32'h0004_0046, 1'b0);
      pop_check("t3_over");
      fill_pay(5); send_frame(32'h0005_0005, 1'b0);
      pop_check("t3_clean");

      // 4: inter-byte timeout after two header bytes
      send_byte(8'h00);
      send_byte(8'h06);
      n = 0;
      while (!timeout && n < 1100) begin
         @(negedge clk);
         n++;
      end
      check("t4_tmo_cycles", n, 1000);
      @(negedge clk);
      check("t4_pulse_width", timeout, 0);
      check("t4_no_commit", bdge_valid, 0);
      fill_pay(6); send_frame(32'h0006_0004, 1'b0);
      pop_check("t4_after");

      // 5: zero-length frames, incl. pop in the commit cycle
      send_frame(32'h0007_0000, 1'b0);
      check("t5_latency", bdge_valid, 1);
      pop_check("t5_len0");
      send_frame(32'h0008_0000, 1'b0);
      sb.push_back('{hdr: 32'h0009_0000, msg: '0, err: 1'b0});
      send_byte(8'h00); send_byte(8'h09); send_byte(8'h00);
      check("t5_head_a", header, 32'h0008_0000);
      void'(sb.pop_front());
      ll_valid = 1'b1; ll_byte = 8'h00; ctrl_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ll_valid = 1'b0; ctrl_ready = 1'b0;
      check("t5_count_stable", bdge_valid, 1);
      pop_check("t5_b");
      check("t5_empty", bdge_valid, 0);

      // 6: checksum pass/fail (checksum builds), reset mid-payload
      if (CHK_BUILD) begin
         fill_pay(9); send_frame(32'h000A_0003, 1'b0);
         pop_check("t6_chk_ok");
         send_frame(32'h000B_0003, 1'b1);
         pop_check("t6_chk_bad");
      end
      fill_pay(11); send_frame(32'h000C_0002, 1'b0);
      send_byte(8'h00); send_byte(8'h0D); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'h11); send_byte(8'h22);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_valid", bdge_valid, 0);
      check("t6_rst_hdr", header, 0);
      check("t6_rst_msg", message, 0);
      sb.delete();
      rst_n = 1'b1;
      @(negedge clk);
      fill_pay(10); send_frame(32'h000E_0003, 1'b0);
      pop_check("t6_after_rst");
      check("t6_empty", bdge_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
